// File: rtl/f_stage_fetch_pkg.sv
// rtl/f_stage_fetch_pkg.sv - shared fetch-stage state encodings, address map defaults and fault check
package f_stage_fetch_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_IMEM_LO  = 32'h0000_3000;
    localparam logic [31:0] DEF_IMEM_HI  = 32'h0000_6FFF;

    typedef enum logic {
        FETCH_S_REQ  = 1'b0,
        FETCH_S_HOLD = 1'b1
    } fetch_state_t;

    // Misaligned or outside instruction memory: the fetch is never issued.
    function automatic logic fetch_fault(input logic [31:0] pc,
                                         input logic [31:0] lo,
                                         input logic [31:0] hi);
        return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
    endfunction

endpackage

// File: rtl/f_stage_fetch_fd_reg.sv
// rtl/f_stage_fetch_fd_reg.sv - F/D pipeline register with load enable and synchronous reset
module f_stage_fetch_fd_reg
    import f_stage_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        adel,
    output logic [31:0] pc_q,
    output logic [31:0] instr_q,
    output logic        valid_q,
    output logic        adel_q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            valid_q <= 1'b0;
            adel_q  <= 1'b0;
        end else if (en) begin
            pc_q    <= pc;
            instr_q <= instr;
            valid_q <= 1'b1;
            adel_q  <= adel;
        end
    end

endmodule

// File: rtl/f_stage_fetch.sv
// rtl/f_stage_fetch.sv - F-stage PC owner: fetch handshake, stall buffer and F/D register
module f_stage_fetch
    import f_stage_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] IMEM_LO  = DEF_IMEM_LO,
    parameter logic [31:0] IMEM_HI  = DEF_IMEM_HI
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] F_PC,
    output logic [31:0] D_PC,
    output logic [31:0] D_instr,
    output logic        D_valid,
    output logic        D_adel,
    output logic        fetch_busy
);

    fetch_state_t state, state_n;
    logic [31:0]  ibuf;
    logic         ibuf_adel;
    logic         fault;
    logic         done;
    logic         fd_en;
    logic         ibuf_load;
    logic [31:0]  fetch_rdata;
    logic [31:0]  fd_instr;
    logic         fd_adel;

    assign fault       = fetch_fault(F_PC, IMEM_LO, IMEM_HI);
    assign imem_addr   = F_PC;
    assign fetch_rdata = fault ? 32'd0 : imem_rdata;
    // Independent of stall so the hazard unit sees no combinational loop.
    assign fetch_busy  = (state == FETCH_S_REQ) && !fault && !imem_ack;

    always_comb begin
        state_n   = state;
        imem_req  = 1'b0;
        done      = 1'b0;
        fd_en     = 1'b0;
        ibuf_load = 1'b0;
        fd_instr  = fetch_rdata;
        fd_adel   = fault;
        case (state)
            FETCH_S_REQ: begin
                imem_req = !fault;
                done     = fault || imem_ack;
                if (done) begin
                    if (stall) begin
                        ibuf_load = 1'b1;
                        state_n   = FETCH_S_HOLD;
                    end else begin
                        fd_en = 1'b1;
                    end
                end
            end
            FETCH_S_HOLD: begin
                fd_instr = ibuf;
                fd_adel  = ibuf_adel;
                if (!stall) begin
                    fd_en   = 1'b1;
                    state_n = FETCH_S_REQ;
                end
            end
            default: state_n = FETCH_S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH_S_REQ;
            F_PC      <= RESET_PC;
            ibuf      <= 32'd0;
            ibuf_adel <= 1'b0;
        end else begin
            state <= state_n;
            if (fd_en) begin
                F_PC <= npc;
            end
            if (ibuf_load) begin
                ibuf      <= fetch_rdata;
                ibuf_adel <= fault;
            end
        end
    end

    f_stage_fetch_fd_reg #(
        .RESET_PC (RESET_PC)
    ) u_fd_reg (
        .clk     (clk),
        .reset   (reset),
        .en      (fd_en),
        .pc      (F_PC),
        .instr   (fd_instr),
        .adel    (fd_adel),
        .pc_q    (D_PC),
        .instr_q (D_instr),
        .valid_q (D_valid),
        .adel_q  (D_adel)
    );

endmodule

// File: tb/tb_f_stage_fetch.sv
// tb/tb_f_stage_fetch.sv - directed and randomized scoreboard bench for f_stage_fetch
module tb_f_stage_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] npc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] F_PC;
    logic [31:0] D_PC;
    logic [31:0] D_instr;
    logic        D_valid;
    logic        D_adel;
    logic        fetch_busy;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] salt;
    int          npc_mode;
    logic [31:0] npc_fixed;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } exp_t;

    exp_t        exp_q[$];
    bit          sb_on = 1'b0;
    int          pops = 0;
    logic [31:0] prev_pc = 32'd0;
    logic        prev_valid = 1'b0;

    always #5 clk = ~clk;

    f_stage_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .npc        (npc),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .F_PC       (F_PC),
        .D_PC       (D_PC),
        .D_instr    (D_instr),
        .D_valid    (D_valid),
        .D_adel     (D_adel),
        .fetch_busy (fetch_busy)
    );

    function automatic logic is_legal(input logic [31:0] pc);
        return (pc[1:0] == 2'b00) && (pc >= 32'h0000_3000) && (pc <= 32'h0000_6FFF);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return (pc * 32'h0100_0193) ^ salt ^ 32'h5A5A_0000;
    endfunction

    // Program flow: mostly sequential, some in-range jumps, some illegal targets.
    function automatic logic [31:0] next_of(input logic [31:0] pc);
        logic [31:0] h;
        logic [31:0] n;
        h = (pc ^ salt) * 32'h9E37_79B1;
        if (h[31:28] < 4'd10)       n = pc + 32'd4;
        else if (h[31:28] < 4'd13)  n = 32'h0000_3000 + {18'd0, h[13:2], 2'b00};
        else if (h[31:28] == 4'd13) n = pc + 32'd2;
        else if (h[31:28] == 4'd14) n = 32'h0000_7000 + {24'd0, h[7:2], 2'b00};
        else                        n = pc | 32'd1;
        if (n == pc) n = pc + 32'd4;
        return n;
    endfunction

    assign npc = (npc_mode == 1) ? npc_fixed :
                 (npc_mode == 2) ? F_PC + 32'd4 : next_of(F_PC);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a new D instruction is a rise of D_valid or a change of D_PC.
    always @(negedge clk) begin
        exp_t e;
        if (sb_on && !reset && D_valid && (!prev_valid || D_PC !== prev_pc)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty actual=%h required=none", D_PC);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", D_PC, e.pc);
                chk("sb_instr", D_instr, e.instr);
                chk("sb_adel", 32'(D_adel), 32'(e.adel));
                pops++;
            end
        end
        prev_valid = D_valid;
        prev_pc    = D_PC;
    end

    initial begin
        logic [31:0] a;
        int          lat;
        int          cyc;
        logic        fire;

        reset = 1'b1; stall = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
        npc_mode = 2; npc_fixed = 32'd0; salt = $urandom;
        nxt(); nxt();
        @(negedge clk);
        chk("rst_fpc", F_PC, 32'h3000);
        chk("rst_dpc", D_PC, 32'h3000);
        chk("rst_dinstr", D_instr, 32'd0);
        chk("rst_dvalid", 32'(D_valid), 32'd0);
        chk("rst_dadel", 32'(D_adel), 32'd0);

        // Sequential fetch, then slow memory at 0x3004.
        nxt(); reset = 1'b0; imem_ack = 1'b1; imem_rdata = mem_word(32'h3000);
        @(negedge clk);
        chk("t1_fpc0", F_PC, 32'h3000);
        chk("t1_req0", 32'(imem_req), 32'd1);
        chk("t1_dvalid0", 32'(D_valid), 32'd0);
        nxt(); imem_ack = 1'b0;
        @(negedge clk);
        chk("t1_fpc1", F_PC, 32'h3004);
        chk("t1_dpc1", D_PC, 32'h3000);
        chk("t1_dvalid1", 32'(D_valid), 32'd1);
        chk("t1_dinstr1", D_instr, mem_word(32'h3000));
        chk("t2_busy0", 32'(fetch_busy), 32'd1);
        nxt();
        @(negedge clk);
        chk("t2_busy1", 32'(fetch_busy), 32'd1);
        chk("t2_fpc_hold", F_PC, 32'h3004);
        chk("t2_dpc_hold", D_PC, 32'h3000);
        nxt(); imem_ack = 1'b1; imem_rdata = mem_word(32'h3004);
        @(negedge clk);
        chk("t2_busy_ack", 32'(fetch_busy), 32'd0);

        // Ack under stall goes to the buffer.
        nxt(); stall = 1'b1; imem_rdata = 32'h8C01_0000;
        @(negedge clk);
        chk("t2_dinstr", D_instr, mem_word(32'h3004));
        chk("t2_fpc", F_PC, 32'h3008);
        nxt(); imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t3_req_hold0", 32'(imem_req), 32'd0);
        chk("t3_fpc_hold", F_PC, 32'h3008);
        chk("t3_dpc_hold", D_PC, 32'h3004);
        chk("t3_busy_hold", 32'(fetch_busy), 32'd0);
        nxt();
        @(negedge clk);
        chk("t3_req_hold1", 32'(imem_req), 32'd0);
        nxt(); stall = 1'b0;
        @(negedge clk);
        chk("t3_req_hold2", 32'(imem_req), 32'd0);
        nxt(); imem_ack = 1'b1; imem_rdata = mem_word(32'h300C);
        npc_mode = 1; npc_fixed = 32'h3002;
        @(negedge clk);
        chk("t3_dinstr", D_instr, 32'h8C01_0000);
        chk("t3_dpc", D_PC, 32'h3008);
        chk("t3_fpc", F_PC, 32'h300C);
        chk("t3_addr", imem_addr, 32'h300C);
        chk("t3_req", 32'(imem_req), 32'd1);

        // Illegal fetch addresses.
        nxt(); imem_ack = 1'b0; npc_fixed = 32'h7000;
        @(negedge clk);
        chk("t4_fpc_mis", F_PC, 32'h3002);
        chk("t4_req_mis", 32'(imem_req), 32'd0);
        chk("t4_busy_mis", 32'(fetch_busy), 32'd0);
        nxt(); npc_fixed = 32'h3000;
        @(negedge clk);
        chk("t4_dpc_mis", D_PC, 32'h3002);
        chk("t4_dinstr_mis", D_instr, 32'd0);
        chk("t4_dadel_mis", 32'(D_adel), 32'd1);
        chk("t4_req_hi", 32'(imem_req), 32'd0);
        chk("t4_busy_hi", 32'(fetch_busy), 32'd0);
        nxt(); npc_fixed = 32'h3008; imem_ack = 1'b1; imem_rdata = mem_word(32'h3000);
        @(negedge clk);
        chk("t4_dpc_hi", D_PC, 32'h7000);
        chk("t4_dadel_hi", 32'(D_adel), 32'd1);
        chk("t4_dinstr_hi", D_instr, 32'd0);

        // Jump in D while delay slot fetch is outstanding.
        nxt(); npc_fixed = 32'h3400; imem_ack = 1'b0;
        @(negedge clk);
        chk("t5_fpc0", F_PC, 32'h3008);
        chk("t5_dadel", 32'(D_adel), 32'd0);
        chk("t5_busy", 32'(fetch_busy), 32'd1);
        nxt();
        @(negedge clk);
        chk("t5_fpc1", F_PC, 32'h3008);
        nxt(); imem_ack = 1'b1; imem_rdata = mem_word(32'h3008);
        nxt(); stall = 1'b1; imem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("t5_dpc", D_PC, 32'h3008);
        chk("t5_dinstr", D_instr, mem_word(32'h3008));
        chk("t5_fpc", F_PC, 32'h3400);

        // Reset while holding a buffered instruction.
        nxt(); reset = 1'b1; imem_ack = 1'b0;
        @(negedge clk);
        chk("t6_req_hold", 32'(imem_req), 32'd0);
        nxt(); reset = 1'b0; stall = 1'b0; imem_ack = 1'b1;
        imem_rdata = mem_word(32'h3000); npc_fixed = 32'h3004;
        @(negedge clk);
        chk("t6_fpc", F_PC, 32'h3000);
        chk("t6_dvalid", 32'(D_valid), 32'd0);
        chk("t6_req", 32'(imem_req), 32'd1);
        nxt();
        @(negedge clk);
        chk("t6_dinstr", D_instr, mem_word(32'h3000));
        chk("t6_dpc", D_PC, 32'h3000);
        chk("t6_fpc2", F_PC, 32'h3004);

        // Randomized run against the program-flow model.
        reset = 1'b1; stall = 1'b0; imem_ack = 1'b0; npc_mode = 0;
        exp_q.delete();
        a = 32'h3000;
        for (int k = 0; k < 150; k++) begin
            exp_q.push_back('{pc: a, instr: is_legal(a) ? mem_word(a) : 32'd0, adel: !is_legal(a)});
            a = next_of(a);
        end
        sb_on = 1'b1;
        nxt(); nxt();
        reset = 1'b0;
        lat = $urandom_range(0, 2);
        cyc = 0;
        while (pops < 100 && cyc < 4000) begin
            stall = ($urandom_range(0, 3) == 0);
            if (imem_req) begin
                if (lat == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = $urandom;
                    lat--;
                end
            end else begin
                imem_ack   = ($urandom_range(0, 2) == 0);
                imem_rdata = $urandom;
            end
            fire = imem_req && imem_ack;
            nxt();
            cyc++;
            if (fire) lat = $urandom_range(0, 2);
        end
        checks++;
        if (pops < 100) begin
            errors++;
            $display("FAIL sb_progress actual=%0d required=100", pops);
        end
        sb_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
